// File: rtl/dice_roll_ctrl.sv
// Purpose : sequences an 8-bit LFSR into one Craps roll (two dice 1..6, their sum, done pulse).
// Latency : 2*(SETTLE_CYCLES+1)+1 cycles nominal from roll accept to o_roll_done; +SETTLE_CYCLES+1 per reject.
// Backpr. : requests are only sampled in IDLE; i_roll_req / i_seed_load are ignored while o_busy=1.
//
// Ports:
//   i_clock, i_reset        single clock, synchronous active-high reset
//   i_roll_req              start a roll (IDLE only)
//   i_seed_load, i_seed_in  load a new LFSR seed (IDLE only, wins over i_roll_req)
//   i_lfsr_num              registered LFSR output, advances the cycle after o_lfsr_en=1
//   o_lfsr_en, o_lfsr_reset, o_lfsr_seed   LFSR control
//   o_busy, o_roll_done     status / one-cycle completion pulse
//   o_die1, o_die2, o_sum, o_fallback      result of the last completed roll
module dice_roll_ctrl #(
    parameter logic [7:0] SEED_DEFAULT  = 8'h01,
    parameter int         SETTLE_CYCLES = 3,
    parameter int         MAX_REJECT    = 8
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_roll_req,
    input  logic       i_seed_load,
    input  logic [7:0] i_seed_in,
    input  logic [7:0] i_lfsr_num,
    output logic       o_lfsr_en,
    output logic       o_lfsr_reset,
    output logic [7:0] o_lfsr_seed,
    output logic       o_busy,
    output logic       o_roll_done,
    output logic [2:0] o_die1,
    output logic [2:0] o_die2,
    output logic [3:0] o_sum,
    output logic       o_fallback
);

    localparam int STW = $clog2(SETTLE_CYCLES + 1);
    localparam int RJW = $clog2(MAX_REJECT + 1);
    localparam logic [STW-1:0] STEP_LAST = STW'(SETTLE_CYCLES - 1);
    localparam logic [RJW-1:0] REJ_LAST  = RJW'(MAX_REJECT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEED   = 3'd1,
        S_STEP   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [7:0]     r_seed;
    logic [STW-1:0] r_step_cnt;
    logic [RJW-1:0] r_rej_cnt;
    logic           r_die_idx;
    logic [2:0]     r_stg_die1;
    logic           r_stg_fb1;
    logic [2:0]     r_die1;
    logic [2:0]     r_die2;
    logic [3:0]     r_sum;
    logic           r_fallback;

    // Sample evaluation: low three bits are uniform over 0..7; 0 and 7 are
    // discarded. After MAX_REJECT discards the modulo mapping bounds latency
    // at the cost of a small bias, which o_fallback reports.
    logic [2:0]     w_raw;
    logic           w_valid;
    logic           w_last_try;
    logic [7:0]     w_mod6;
    logic [2:0]     w_fb_die;
    logic [2:0]     w_die;
    logic           w_accept;

    assign w_raw      = i_lfsr_num[2:0];
    assign w_valid    = (w_raw != 3'd0) && (w_raw != 3'd7);
    assign w_last_try = (r_rej_cnt == REJ_LAST);
    assign w_mod6     = i_lfsr_num % 8'd6;
    assign w_fb_die   = w_mod6[2:0] + 3'd1;
    assign w_die      = w_valid ? w_raw : w_fb_die;
    assign w_accept   = (r_state == S_SAMPLE) && (w_valid || w_last_try);

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_seed_load) begin
                    w_next = S_SEED;
                end else if (i_roll_req) begin
                    w_next = S_STEP;
                end
            end
            S_SEED:   w_next = S_IDLE;
            S_STEP: begin
                if (r_step_cnt == STEP_LAST) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_accept && r_die_idx) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_STEP;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Outputs. Everything except o_lfsr_reset is forced low while i_reset is
    // high so the LFSR is never stepped during its own reload.
    always_comb begin
        o_lfsr_en    = 1'b0;
        o_lfsr_reset = i_reset;
        o_busy       = 1'b0;
        o_roll_done  = 1'b0;
        if (!i_reset) begin
            o_lfsr_en    = (r_state == S_STEP);
            o_lfsr_reset = (r_state == S_SEED);
            o_busy       = (r_state != S_IDLE);
            o_roll_done  = (r_state == S_DONE);
        end
    end

    // Datapath: seed, counters, die staging and result registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_seed     <= SEED_DEFAULT;
            r_step_cnt <= '0;
            r_rej_cnt  <= '0;
            r_die_idx  <= 1'b0;
            r_stg_die1 <= 3'd0;
            r_stg_fb1  <= 1'b0;
            r_die1     <= 3'd0;
            r_die2     <= 3'd0;
            r_sum      <= 4'd0;
            r_fallback <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_seed_load) begin
                        // A zero seed would lock the LFSR at zero.
                        r_seed <= (i_seed_in == 8'h00) ? SEED_DEFAULT : i_seed_in;
                    end else if (i_roll_req) begin
                        r_die_idx  <= 1'b0;
                        r_rej_cnt  <= '0;
                        r_step_cnt <= '0;
                    end
                end
                S_STEP: begin
                    if (r_step_cnt == STEP_LAST) begin
                        r_step_cnt <= '0;
                    end else begin
                        r_step_cnt <= r_step_cnt + STW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (w_accept) begin
                        if (!r_die_idx) begin
                            r_stg_die1 <= w_die;
                            r_stg_fb1  <= !w_valid;
                            r_die_idx  <= 1'b1;
                            r_rej_cnt  <= '0;
                        end else begin
                            // Results publish together so they are valid in the DONE cycle.
                            r_die1     <= r_stg_die1;
                            r_die2     <= w_die;
                            r_sum      <= {1'b0, r_stg_die1} + {1'b0, w_die};
                            r_fallback <= r_stg_fb1 | !w_valid;
                        end
                    end else begin
                        r_rej_cnt <= r_rej_cnt + RJW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_lfsr_seed = r_seed;
    assign o_die1      = r_die1;
    assign o_die2      = r_die2;
    assign o_sum       = r_sum;
    assign o_fallback  = r_fallback;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
module tb_dice_roll_ctrl;

    localparam int S  = 3;
    localparam int MR = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       roll_req = 1'b0;
    logic       seed_load = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic [7:0] lfsr_num = 8'h00;
    logic       lfsr_en, lfsr_reset, busy, roll_done, fallback;
    logic [7:0] lfsr_seed;
    logic [2:0] die1, die2;
    logic [3:0] sum;

    logic       fb_req = 1'b0;
    logic       fb_seed_load = 1'b0;
    logic [7:0] fb_seed_in = 8'h00;
    logic [7:0] fb_num = 8'hFF;
    logic       fb_en, fb_lreset, fb_busy, fb_done, fb_fallback;
    logic [7:0] fb_seed;
    logic [2:0] fb_die1, fb_die2;
    logic [3:0] fb_sum;

    always #5 clk = ~clk;

    dice_roll_ctrl dut (
        .i_clock(clk), .i_reset(rst), .i_roll_req(roll_req), .i_seed_load(seed_load),
        .i_seed_in(seed_in), .i_lfsr_num(lfsr_num), .o_lfsr_en(lfsr_en),
        .o_lfsr_reset(lfsr_reset), .o_lfsr_seed(lfsr_seed), .o_busy(busy),
        .o_roll_done(roll_done), .o_die1(die1), .o_die2(die2), .o_sum(sum),
        .o_fallback(fallback)
    );

    dice_roll_ctrl #(.MAX_REJECT(2)) dut_fb (
        .i_clock(clk), .i_reset(rst), .i_roll_req(fb_req), .i_seed_load(fb_seed_load),
        .i_seed_in(fb_seed_in), .i_lfsr_num(fb_num), .o_lfsr_en(fb_en),
        .o_lfsr_reset(fb_lreset), .o_lfsr_seed(fb_seed), .o_busy(fb_busy),
        .o_roll_done(fb_done), .o_die1(fb_die1), .o_die2(fb_die2), .o_sum(fb_sum),
        .o_fallback(fb_fallback)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scripted LFSR stub: each sample is preceded by S enabled steps; the value
    // presented after the last step is the next scripted sample.
    logic [7:0] script_q[$];
    int stub_steps = 0;
    always @(posedge clk) begin
        if (lfsr_reset) begin
            stub_steps = 0;
            lfsr_num <= lfsr_seed;
        end else if (lfsr_en) begin
            if (stub_steps == S - 1) begin
                stub_steps = 0;
                lfsr_num <= (script_q.size() > 0) ? script_q.pop_front() : 8'h00;
            end else begin
                stub_steps++;
                lfsr_num <= 8'h00;
            end
        end
    end

    // Behavioural model: a roll is a list of samples; its length fixes how long
    // the DUT is busy, and the rules pick the dice out of the list.
    logic [7:0] model_q[$];
    int         m_rem = 0;
    int         m_len = 0;
    bit         m_seedcyc = 1'b0;
    logic [7:0] m_seed = 8'h01;
    logic [2:0] m_d1 = 3'd0, m_d2 = 3'd0, p_d1 = 3'd0, p_d2 = 3'd0;
    logic [3:0] m_sum = 4'd0, p_sum = 4'd0;
    logic       m_fb = 1'b0, p_fb = 1'b0;

    task automatic model_roll();
        int nsamp;
        logic [2:0] val [2];
        logic       fbb [2];
        logic [7:0] v;
        bit got;
        nsamp = 0;
        for (int d = 0; d < 2; d++) begin
            got = 1'b0;
            val[d] = 3'd0;
            fbb[d] = 1'b0;
            for (int r = 0; r < MR && !got; r++) begin
                v = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
                nsamp++;
                if (v[2:0] >= 3'd1 && v[2:0] <= 3'd6) begin
                    val[d] = v[2:0];
                    got = 1'b1;
                end else if (r == MR - 1) begin
                    val[d] = 3'(int'(v) % 6 + 1);
                    fbb[d] = 1'b1;
                    got = 1'b1;
                end
            end
        end
        p_d1  = val[0];
        p_d2  = val[1];
        p_sum = 4'(int'(val[0]) + int'(val[1]));
        p_fb  = fbb[0] | fbb[1];
        m_len = nsamp * (S + 1) + 1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_rem = 0; m_seedcyc = 1'b0; m_seed = 8'h01;
            m_d1 = 3'd0; m_d2 = 3'd0; m_sum = 4'd0; m_fb = 1'b0;
        end else if (m_seedcyc) begin
            m_seedcyc = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 1) begin
                m_d1 = p_d1; m_d2 = p_d2; m_sum = p_sum; m_fb = p_fb;
            end
        end else if (seed_load) begin
            m_seed = (seed_in == 8'h00) ? 8'h01 : seed_in;
            m_seedcyc = 1'b1;
        end else if (roll_req) begin
            model_roll();
            m_rem = m_len;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            int off;
            off = m_len - m_rem + 1;
            chk("busy", busy, !rst && (m_rem > 0 || m_seedcyc));
            chk("roll_done", roll_done, !rst && m_rem == 1);
            chk("lfsr_en", lfsr_en, !rst && m_rem > 1 && (off % (S + 1)) != 0);
            chk("lfsr_reset", lfsr_reset, rst | m_seedcyc);
            chk("en_and_reset", lfsr_en & lfsr_reset, 1'b0);
            chk("lfsr_seed", lfsr_seed, m_seed);
            chk("die1", die1, m_d1);
            chk("die2", die2, m_d2);
            chk("sum", sum, m_sum);
            chk("fallback", fallback, m_fb);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [7:0] a, input logic [7:0] b);
        script_q.push_back(a); model_q.push_back(a);
        script_q.push_back(b); model_q.push_back(b);
    endtask

    task automatic start_roll(output int t0);
        step(); roll_req = 1'b1;
        step(); roll_req = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (roll_done) begin
                lat = cyc - t0 + 1;
                break;
            end
        end
        if (lat < 0) chk("roll_done_timeout", 0, 1);
    endtask

    task automatic check_roll(input string tag, input int t0, input int exp_lat,
                              input int e1, input int e2, input int es, input int ef);
        int lat;
        wait_done(t0, lat);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_die1"}, die1, e1);
        chk({tag, "_die2"}, die2, e2);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_fallback"}, fallback, ef);
    endtask

    initial begin
        int t0, lat, cnt, d[3], k;
        int exp_d1[3], exp_d2[3];

        rst = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        @(negedge clk);
        chk("rst_lfsr_reset", lfsr_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_seed", lfsr_seed, 8'h01);
        chk("rst_sum", sum, 0);
        step(); rst = 1'b0;

        // 1. Basic roll
        push2(8'h05, 8'h03);
        start_roll(t0);
        check_roll("basic", t0, 9, 5, 3, 8, 0);

        // 2. Rejection on die1
        script_q.push_back(8'h07); model_q.push_back(8'h07);
        push2(8'h02, 8'h06);
        start_roll(t0);
        check_roll("reject", t0, 13, 2, 6, 8, 0);

        // 3. Fallback on a MAX_REJECT=2 instance with the LFSR stuck at FF
        step(); fb_req = 1'b1;
        step(); fb_req = 1'b0;
        t0 = cyc; lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fb_done) begin lat = cyc - t0 + 1; break; end
        end
        chk("fb_latency", lat, 17);
        chk("fb_die1", fb_die1, 4);
        chk("fb_die2", fb_die2, 4);
        chk("fb_sum", fb_sum, 8);
        chk("fb_flag", fb_fallback, 1);

        // 4. Seed load with a same-cycle roll_req, then a zero seed
        step(); seed_load = 1'b1; roll_req = 1'b1; seed_in = 8'h3C;
        step(); seed_load = 1'b0; roll_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (lfsr_reset) cnt++;
            if (busy && i > 0) chk("seed_no_roll", busy, 0);
        end
        chk("seed_pulse_cnt", cnt, 1);
        chk("seed_3c", lfsr_seed, 8'h3C);
        step(); seed_load = 1'b1; seed_in = 8'h00;
        step(); seed_load = 1'b0;
        @(negedge clk);
        chk("seed_zero_pulse", lfsr_reset, 1);
        step();
        chk("seed_zero", lfsr_seed, 8'h01);

        // 5. Reset in the middle of a roll
        push2(8'h05, 8'h03);
        start_roll(t0);
        repeat (5) step();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_lfsr_reset", lfsr_reset, 1);
        chk("midrst_lfsr_en", lfsr_en, 0);
        step(); rst = 1'b0;
        script_q.delete(); model_q.delete();
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_die1", die1, 0);
        chk("midrst_sum", sum, 0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (roll_done) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        push2(8'h05, 8'h03);
        start_roll(t0);
        check_roll("after_rst", t0, 9, 5, 3, 8, 0);

        // 6a. Requests while busy are ignored
        push2(8'h01, 8'h06);
        start_roll(t0);
        step(); roll_req = 1'b1; seed_load = 1'b1; seed_in = 8'hAA;
        step(); roll_req = 1'b0; seed_load = 1'b0;
        check_roll("busy_ignore", t0, 9, 1, 6, 7, 0);
        chk("busy_seed_kept", lfsr_seed, 8'h01);
        repeat (3) step();
        chk("busy_no_second", busy, 0);

        // 6b. Held roll_req gives back-to-back rolls
        exp_d1 = '{2, 6, 3};
        exp_d2 = '{4, 1, 3};
        for (int i = 0; i < 3; i++) push2(8'(exp_d1[i]), 8'(exp_d2[i]));
        step(); roll_req = 1'b1;
        step();
        t0 = cyc; k = 0;
        for (int i = 0; i < 100 && k < 3; i++) begin
            @(negedge clk);
            if (roll_done) begin
                d[k] = cyc;
                chk("held_die1", die1, exp_d1[k]);
                chk("held_die2", die2, exp_d2[k]);
                chk("held_sum", sum, die1 + die2);
                k++;
                if (k == 3) roll_req = 1'b0;
            end
        end
        roll_req = 1'b0;
        chk("held_count", k, 3);
        if (k == 3) begin
            chk("held_first_lat", d[0] - t0 + 1, 9);
            chk("held_gap1", d[1] - d[0], 10);
            chk("held_gap2", d[2] - d[1], 10);
        end
        repeat (4) step();

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
